// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl: prioritised stall resolution, multi-cycle upstream flush, stall watchdog and counter
module stall_flush_ctrl #(
  parameter int STAGES = 7,
  parameter int NREQ = 4,
  parameter logic [NREQ*STAGES-1:0] REQ_MASKS = {7'b0000100, 7'b0001000, 7'b0001100, 7'b0111111},
  parameter logic [STAGES-1:0] RDY_MASK = 7'b1111100,
  parameter int FLUSH_LEN = 2,
  parameter int WDOG_MAX = 1023,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic [NREQ-1:0]            stall_req_i,
  input  logic                       flush_req_i,
  input  logic [$clog2(STAGES)-1:0]  flush_stage_i,
  input  logic                       clr_cnt_i,
  output logic [STAGES-1:0]          stall_sign,
  output logic [$clog2(NREQ+1)-1:0]  stall_src_o,
  output logic [STAGES-1:0]          flush_sign,
  output logic                       wdog_timeout_o,
  output logic [CNT_W-1:0]           stall_cycles_o
);
  localparam int SW = $clog2(NREQ+1);
  localparam int RW = $clog2(WDOG_MAX+1);
  localparam int FW = FLUSH_LEN > 1 ? $clog2(FLUSH_LEN) : 1;
  localparam logic IDLE = 1'b0, FLUSH = 1'b1;
  logic state;
  logic [FW-1:0] fcnt;
  logic [STAGES-1:0] fmask;
  logic [RW-1:0] run, run_nxt;
  logic stalled;
  always_comb begin
    stall_sign = '0;
    stall_src_o = SW'(NREQ);
    if (rst && !rdy) stall_sign = RDY_MASK;
    else if (rst)
      for (int i = NREQ-1; i >= 0; i--)
        if (stall_req_i[i]) begin
          stall_sign = REQ_MASKS[i*STAGES +: STAGES];
          stall_src_o = SW'(i);
        end
  end
  // every stage strictly below k is flushed; out-of-range k naturally yields all-ones
  always_comb begin
    fmask = '0;
    for (int j = 0; j < STAGES; j++) fmask[j] = j < int'(flush_stage_i);
  end
  assign stalled = rdy && |stall_sign;
  assign run_nxt = clr_cnt_i ? '0 :
                   stalled ? (run == RW'(WDOG_MAX) ? run : run + RW'(1)) :
                   ~|stall_sign ? '0 : run;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      fcnt <= '0;
      flush_sign <= '0;
      run <= '0;
      wdog_timeout_o <= 1'b0;
      stall_cycles_o <= '0;
    end else begin
      if (flush_req_i) begin
        state <= FLUSH;
        flush_sign <= flush_sign | fmask;
        fcnt <= FW'(FLUSH_LEN-1);
      end else if (state == FLUSH && rdy) begin
        if (fcnt == '0) begin
          state <= IDLE;
          flush_sign <= '0;
        end else fcnt <= fcnt - FW'(1);
      end
      run <= run_nxt;
      wdog_timeout_o <= !clr_cnt_i && (wdog_timeout_o || run_nxt == RW'(WDOG_MAX));
      stall_cycles_o <= clr_cnt_i ? '0 : (stalled && ~&stall_cycles_o) ? stall_cycles_o + CNT_W'(1) : stall_cycles_o;
    end
  end
endmodule

// File: tb/tb_stall_flush_ctrl.sv
// tb_stall_flush_ctrl: directed vector table plus multi-cycle flush, counter, watchdog and reset sequences
module tb_stall_flush_ctrl;
  logic clk = 0, rst, rdy, flush_req_i, clr_cnt_i;
  logic [3:0] stall_req_i;
  logic [2:0] flush_stage_i;
  logic [6:0] stall_sign, flush_sign;
  logic [2:0] stall_src_o;
  logic wdog_timeout_o;
  logic [31:0] stall_cycles_o;
  int nvec = 0, nerr = 0;

  stall_flush_ctrl #(.WDOG_MAX(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req_i(stall_req_i), .flush_req_i(flush_req_i),
    .flush_stage_i(flush_stage_i), .clr_cnt_i(clr_cnt_i), .stall_sign(stall_sign),
    .stall_src_o(stall_src_o), .flush_sign(flush_sign), .wdog_timeout_o(wdog_timeout_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rdy;
    logic [3:0] req;
    logic [6:0] stall;
    logic [2:0] src;
  } vec_t;
  vec_t v[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic settle_chk_flush(input string n, input logic [6:0] e);
    #2;
    chk(n, 64'(flush_sign), 64'(e));
  endtask

  task automatic do_reset();
    rst = 0; rdy = 1; stall_req_i = 0; flush_req_i = 0; flush_stage_i = 0; clr_cnt_i = 0;
    tick(); tick();
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{1'b0, 1'b1, 4'b1111, 7'b0000000, 3'd4};
    v[1] = '{1'b1, 1'b1, 4'b0000, 7'b0000000, 3'd4};
    v[2] = '{1'b1, 1'b1, 4'b1110, 7'b0001100, 3'd1};
    v[3] = '{1'b1, 1'b1, 4'b0001, 7'b0111111, 3'd0};
    v[4] = '{1'b1, 1'b1, 4'b1000, 7'b0000100, 3'd3};
    v[5] = '{1'b1, 1'b1, 4'b0100, 7'b0001000, 3'd2};
    v[6] = '{1'b1, 1'b1, 4'b1100, 7'b0001000, 3'd2};
    v[7] = '{1'b1, 1'b0, 4'b1111, 7'b1111100, 3'd4};
    v[8] = '{1'b1, 1'b0, 4'b0000, 7'b1111100, 3'd4};
    v[9] = '{1'b1, 1'b1, 4'b1010, 7'b0001100, 3'd1};

    do_reset();
    rst = 0;
    #2;
    chk("reset_flush", 64'(flush_sign), 0);
    chk("reset_wdog", 64'(wdog_timeout_o), 0);
    chk("reset_cnt", 64'(stall_cycles_o), 0);
    tick();
    rst = 1;

    for (int i = 0; i < 10; i++) begin
      rst = v[i].rst; rdy = v[i].rdy; stall_req_i = v[i].req;
      #2;
      chk($sformatf("vec%0d_stall", i), 64'(stall_sign), 64'(v[i].stall));
      chk($sformatf("vec%0d_src", i), 64'(stall_src_o), 64'(v[i].src));
      tick();
    end

    do_reset();
    flush_req_i = 1; flush_stage_i = 4;
    settle_chk_flush("flush_t", 7'b0000000);
    tick(); flush_req_i = 0;
    settle_chk_flush("flush_t1", 7'b0001111);
    tick();
    settle_chk_flush("flush_t2", 7'b0001111);
    tick();
    settle_chk_flush("flush_t3", 7'b0000000);

    flush_req_i = 1; flush_stage_i = 4;
    tick(); flush_stage_i = 2;
    settle_chk_flush("merge_t1", 7'b0001111);
    tick(); flush_req_i = 0; rdy = 0;
    settle_chk_flush("merge_t2", 7'b0001111);
    tick();
    settle_chk_flush("merge_t3", 7'b0001111);
    tick();
    settle_chk_flush("merge_t4", 7'b0001111);
    tick(); rdy = 1;
    settle_chk_flush("merge_t5", 7'b0001111);
    tick(); tick();
    settle_chk_flush("merge_t7", 7'b0000000);

    flush_req_i = 1; flush_stage_i = 7;
    tick(); flush_req_i = 0;
    settle_chk_flush("clamp_k7", 7'b1111111);
    tick(); tick();
    settle_chk_flush("clamp_done", 7'b0000000);
    flush_req_i = 1; flush_stage_i = 0;
    tick(); flush_req_i = 0;
    settle_chk_flush("k0_mask", 7'b0000000);
    tick(); tick();

    do_reset();
    stall_req_i = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      rdy = !(i == 2 || i == 5 || i == 7);
      tick();
    end
    stall_req_i = 0; rdy = 1;
    #2;
    chk("cnt_7", 64'(stall_cycles_o), 7);
    stall_req_i = 4'b0001; clr_cnt_i = 1;
    tick(); clr_cnt_i = 0;
    #2;
    chk("cnt_clr", 64'(stall_cycles_o), 0);
    tick(); stall_req_i = 0;
    #2;
    chk("cnt_after_clr", 64'(stall_cycles_o), 1);

    do_reset();
    stall_req_i = 4'b1000;
    for (int i = 0; i < 7; i++) tick();
    #2;
    chk("wdog_before", 64'(wdog_timeout_o), 0);
    tick(); stall_req_i = 0;
    #2;
    chk("wdog_trip", 64'(wdog_timeout_o), 1);
    tick(); tick();
    chk("wdog_held", 64'(wdog_timeout_o), 1);
    chk("wdog_src_none", 64'(stall_src_o), 4);
    clr_cnt_i = 1;
    tick(); clr_cnt_i = 0;
    #2;
    chk("wdog_clr", 64'(wdog_timeout_o), 0);
    for (int i = 0; i < 9; i++) begin
      stall_req_i = (i == 4) ? 4'b0000 : 4'b1000;
      tick();
    end
    stall_req_i = 0;
    tick();
    chk("wdog_gap", 64'(wdog_timeout_o), 0);

    do_reset();
    stall_req_i = 4'b0001; flush_req_i = 1; flush_stage_i = 4;
    tick(); flush_req_i = 0;
    settle_chk_flush("rst_mid_pre", 7'b0001111);
    rst = 0; flush_req_i = 1; flush_stage_i = 6;
    #2;
    chk("rst_stall_zero", 64'(stall_sign), 0);
    chk("rst_src_none", 64'(stall_src_o), 4);
    tick(); rst = 1; flush_req_i = 0; stall_req_i = 0;
    settle_chk_flush("rst_mid_flush", 7'b0000000);
    chk("rst_mid_cnt", 64'(stall_cycles_o), 0);
    tick();
    settle_chk_flush("rst_no_residual", 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
